// File: rtl/line_clear_engine.sv
// Tetris playfield bitmap: merges locked-piece cells, then scans bottom-up and
// collapses full rows, reporting the removed-row count as a one-cycle pulse.
module line_clear_engine #(
  parameter int ROWS = 20,
  parameter int COLS = 10
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            lock_valid,
  output logic            lock_ready,
  input  logic [15:0]     lock_x,
  input  logic [19:0]     lock_y,
  input  logic            clear_board,
  input  logic [4:0]      rd_row,
  output logic [COLS-1:0] rd_data,
  output logic            busy,
  output logic [3:0]      lines_cleared,
  output logic            top_out
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [4:0] ROWS_W = 5'(ROWS);
  localparam logic [4:0] COLS_W = 5'(COLS);
  localparam logic [4:0] LAST   = 5'(ROWS - 1);

  state_t          state;
  logic [COLS-1:0] board     [ROWS];
  logic [COLS-1:0] lock_mask [ROWS];
  logic [3:0]      cell_x    [4];
  logic [4:0]      cell_y    [4];
  logic [4:0]      ptr;
  logic [3:0]      count;
  logic            row_full;

  // Per-row OR mask of the four incoming cells; out-of-range cells contribute nothing.
  always_comb begin
    for (int unsigned r = 0; r < ROWS; r++) lock_mask[r] = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      cell_x[k] = lock_x[4*k +: 4];
      cell_y[k] = lock_y[5*k +: 5];
      if (({1'b0, cell_x[k]} < COLS_W) && (cell_y[k] < ROWS_W))
        lock_mask[cell_y[k]][cell_x[k]] = 1'b1;
    end
  end

  assign row_full   = &board[ptr];
  assign lock_ready = (state == IDLE) && !clear_board;
  assign busy       = (state != IDLE);
  assign rd_data    = (rd_row < ROWS_W) ? board[rd_row] : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned r = 0; r < ROWS; r++) board[r] <= '0;
      state         <= IDLE;
      ptr           <= LAST;
      count         <= '0;
      lines_cleared <= '0;
      top_out       <= 1'b0;
    end else if (clear_board) begin
      for (int unsigned r = 0; r < ROWS; r++) board[r] <= '0;
      state         <= IDLE;
      ptr           <= LAST;
      count         <= '0;
      lines_cleared <= '0;
      top_out       <= 1'b0;
    end else begin
      lines_cleared <= '0;
      case (state)
        IDLE: begin
          if (lock_valid) begin
            for (int unsigned r = 0; r < ROWS; r++) board[r] <= board[r] | lock_mask[r];
            ptr   <= LAST;
            count <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (row_full) begin
            // Collapse: everything above ptr moves down one; ptr is rechecked.
            for (int unsigned r = 1; r < ROWS; r++)
              if (5'(r) <= ptr) board[r] <= board[r-1];
            board[0] <= '0;
            if (count != 4'hF) count <= count + 4'd1;
          end else if (ptr == 5'd0) begin
            state <= DONE;
          end else begin
            ptr <= ptr - 5'd1;
          end
        end
        DONE: begin
          lines_cleared <= count;
          top_out       <= top_out | (|board[0]);
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_clear_engine.sv
// Directed bench for line_clear_engine: hand-built boards, clear counts,
// pulse timing, range dropping, abort and reset behaviour.
module tb_line_clear_engine;

  localparam int ROWS = 20;
  localparam int COLS = 10;

  logic            clock = 1'b0;
  logic            reset;
  logic            lock_valid;
  logic            lock_ready;
  logic [15:0]     lock_x;
  logic [19:0]     lock_y;
  logic            clear_board;
  logic [4:0]      rd_row;
  logic [COLS-1:0] rd_data;
  logic            busy;
  logic [3:0]      lines_cleared;
  logic            top_out;

  int tests = 0;
  int fails = 0;

  line_clear_engine #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clock(clock), .reset(reset), .lock_valid(lock_valid), .lock_ready(lock_ready),
    .lock_x(lock_x), .lock_y(lock_y), .clear_board(clear_board), .rd_row(rd_row),
    .rd_data(rd_data), .busy(busy), .lines_cleared(lines_cleared), .top_out(top_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] px(input int a, input int b, input int c, input int d);
    return {4'(d), 4'(c), 4'(b), 4'(a)};
  endfunction

  function automatic logic [19:0] py(input int a, input int b, input int c, input int d);
    return {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  task automatic check_row(input string tag, input int r, input logic [COLS-1:0] exp);
    rd_row = 5'(r);
    #1;
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic rows_or(input int lo, input int hi, output logic [COLS-1:0] acc);
    acc = '0;
    for (int r = lo; r <= hi; r++) begin
      rd_row = 5'(r);
      #1;
      acc = acc | rd_data;
    end
  endtask

  task automatic accept_lock(input logic [15:0] x, input logic [19:0] y);
    int n = 0;
    @(negedge clock);
    while (!lock_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("ready_wait", 32'(lock_ready), 32'd1);
    lock_x     = x;
    lock_y     = y;
    lock_valid = 1'b1;
    @(posedge clock);
    #1;
    lock_valid = 1'b0;
    check("ready_drop", 32'(lock_ready), 32'd0);
  endtask

  // Cycle i = sample #1 after the i-th edge following the accept edge.
  task automatic watch(input int n, output int pulses, output logic [3:0] val,
                       output int plat, output int dlat);
    pulses = 0; val = '0; plat = -1; dlat = -1;
    for (int i = 1; i <= n; i++) begin
      @(posedge clock);
      #1;
      if (lines_cleared != 4'd0) begin
        pulses++;
        val  = lines_cleared;
        plat = i;
      end
      if (!busy && dlat < 0) dlat = i;
    end
  endtask

  task automatic lock_wait(input logic [15:0] x, input logic [19:0] y, output int pulses,
                           output logic [3:0] val, output int plat, output int dlat);
    accept_lock(x, y);
    watch(40, pulses, val, plat, dlat);
  endtask

  task automatic fill(input int r, input int c0, input int c1);
    int a [4];
    int p, pl, dl;
    logic [3:0] v;
    for (int c = c0; c <= c1; c += 4) begin
      for (int k = 0; k < 4; k++) a[k] = (c + k <= c1) ? c + k : c1;
      lock_wait(px(a[0], a[1], a[2], a[3]), py(r, r, r, r), p, v, pl, dl);
      check("fill_no_pulse", 32'(p), 32'd0);
    end
  endtask

  task automatic wipe();
    @(negedge clock);
    clear_board = 1'b1;
    @(posedge clock);
    #1;
    clear_board = 1'b0;
  endtask

  initial begin
    int p, pl, dl;
    logic [3:0] v;
    logic [COLS-1:0] acc;

    reset = 1'b1; lock_valid = 1'b0; lock_x = '0; lock_y = '0;
    clear_board = 1'b0; rd_row = 5'd19;
    #23;
    check("rst_ready", 32'(lock_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_lines", 32'(lines_cleared), 32'd0);
    check("rst_top", 32'(top_out), 32'd0);
    check("rst_row19", 32'(rd_data), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Four cells on the bottom row, no full rows.
    accept_lock(px(0, 1, 2, 3), py(19, 19, 19, 19));
    check_row("t1_row19_early", 19, 10'h00F);
    watch(40, p, v, pl, dl);
    check("t1_pulses", 32'(p), 32'd0);
    check("t1_done_lat", 32'(dl), 32'(ROWS + 1));
    check_row("t1_row19", 19, 10'h00F);
    check("t1_top", 32'(top_out), 32'd0);

    // Single line clear; old row 18 drops into row 19.
    wipe();
    fill(19, 0, 5);
    fill(18, 0, 5);
    lock_wait(px(6, 7, 8, 9), py(19, 19, 19, 19), p, v, pl, dl);
    check("t2_pulses", 32'(p), 32'd1);
    check("t2_count", 32'(v), 32'd1);
    check("t2_lat", 32'(pl), 32'(ROWS + 2));
    check_row("t2_row19", 19, 10'h03F);
    check_row("t2_row18", 18, 10'h000);
    check_row("t2_row0", 0, 10'h000);

    // Tetris: four rows with a vertical I.
    wipe();
    for (int r = 16; r <= 19; r++) fill(r, 0, 8);
    lock_wait(px(9, 9, 9, 9), py(16, 17, 18, 19), p, v, pl, dl);
    check("t3_pulses", 32'(p), 32'd1);
    check("t3_count", 32'(v), 32'd4);
    check("t3_lat", 32'(pl), 32'(ROWS + 5));
    check("t3_done_lat", 32'(dl), 32'(ROWS + 5));
    rows_or(0, ROWS - 1, acc);
    check("t3_board_empty", 32'(acc), 32'd0);

    // Non-adjacent full rows 19 and 17 around a partial row 18.
    wipe();
    fill(19, 0, 8);
    fill(17, 0, 8);
    lock_wait(px(0, 2, 4, 6), py(18, 18, 18, 18), p, v, pl, dl);
    lock_wait(px(8, 8, 8, 8), py(18, 18, 18, 18), p, v, pl, dl);
    check_row("t4_row18_pre", 18, 10'h155);
    lock_wait(px(9, 9, 9, 9), py(19, 17, 17, 17), p, v, pl, dl);
    check("t4_pulses", 32'(p), 32'd1);
    check("t4_count", 32'(v), 32'd2);
    check("t4_lat", 32'(pl), 32'(ROWS + 3));
    check_row("t4_row19", 19, 10'h155);
    check_row("t4_row18", 18, 10'h000);

    // Out-of-range cells dropped; row 0 sets sticky top_out.
    wipe();
    check("t5_top_wiped", 32'(top_out), 32'd0);
    lock_wait(px(12, 3, 0, 1), py(5, 25, 0, 0), p, v, pl, dl);
    check("t5_pulses", 32'(p), 32'd0);
    check_row("t5_row0", 0, 10'h003);
    rows_or(1, ROWS - 1, acc);
    check("t5_rest_empty", 32'(acc), 32'd0);
    check_row("t5_rd_oob", 25, 10'h000);
    check("t5_top", 32'(top_out), 32'd1);
    lock_wait(px(0, 1, 2, 3), py(19, 19, 19, 19), p, v, pl, dl);
    check("t5_top_sticky", 32'(top_out), 32'd1);

    // Abort a 2-line clear mid-scan with a coincident lock request.
    wipe();
    fill(19, 0, 8);
    fill(18, 0, 8);
    accept_lock(px(9, 9, 9, 9), py(19, 18, 18, 18));
    p = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #1;
      if (lines_cleared != 4'd0) p++;
    end
    @(negedge clock);
    check("t6_busy_pre", 32'(busy), 32'd1);
    clear_board = 1'b1;
    lock_valid  = 1'b1;
    lock_x      = px(0, 1, 2, 3);
    lock_y      = py(0, 0, 0, 0);
    #1;
    check("t6_ready_low", 32'(lock_ready), 32'd0);
    @(posedge clock);
    #1;
    clear_board = 1'b0;
    lock_valid  = 1'b0;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_top", 32'(top_out), 32'd0);
    check("t6_lines", 32'(lines_cleared), 32'd0);
    rows_or(0, ROWS - 1, acc);
    check("t6_board_empty", 32'(acc), 32'd0);
    watch(30, pl, v, dl, dl);
    check("t6_no_pulse", 32'(p + pl), 32'd0);
    check("t6_stay_idle", 32'(busy), 32'd0);

    // Asynchronous reset mid-scan.
    accept_lock(px(0, 1, 2, 3), py(0, 0, 0, 0));
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("t7_busy", 32'(busy), 32'd0);
    check("t7_ready", 32'(lock_ready), 32'd1);
    check_row("t7_row0", 0, 10'h000);
    @(negedge clock);
    reset = 1'b0;
    watch(25, p, v, pl, dl);
    check("t7_top", 32'(top_out), 32'd0);
    check("t7_no_pulse", 32'(p), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
